// File: rtl/seq_gen.sv
// Serial stimulus generator: shifts a captured pattern out LSB first
// and counts adjacent equal bit pairs as the detector's expected hits.
module seq_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       len,
  output logic             w,
  output logic             valid,
  output logic             done,
  output logic [3:0]       expected_z,
  output logic [2:0]       state
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_SEND = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  localparam int I_IDLE = 0;
  localparam int I_SEND = 1;
  localparam int I_DONE = 2;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [WIDTH-1:0] r_pat;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_last;
  logic [CW-1:0]    w_last;
  logic             r_prev;
  logic [3:0]       r_z;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_end;

  // len of 0 or beyond WIDTH falls back to the full pattern width
  assign w_len_ok = (len != 4'd0) && (32'(len) <= WIDTH);
  assign w_last   = w_len_ok ? CW'(len - 4'd1) : CW'(WIDTH - 1);
  assign w_accept = r_state[I_IDLE] & start;
  assign w_end    = r_state[I_SEND] & (r_cnt == r_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_IDLE;
    unique case (1'b1)
      r_state[I_IDLE]: w_next = start ? S_SEND : S_IDLE;
      r_state[I_SEND]: w_next = w_end ? S_DONE : S_SEND;
      r_state[I_DONE]: w_next = S_IDLE;
      default:         w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w     = 1'b0;
    valid = 1'b0;
    done  = 1'b0;
    unique case (1'b1)
      r_state[I_SEND]: begin
        w     = r_pat[0];
        valid = 1'b1;
      end
      r_state[I_DONE]: done = 1'b1;
      default: ;
    endcase
  end

  // r_pat shifts so the current bit is always r_pat[0]
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pat  <= '0;
      r_cnt  <= '0;
      r_last <= '0;
      r_prev <= 1'b0;
      r_z    <= 4'd0;
    end else if (w_accept) begin
      r_pat  <= pattern;
      r_cnt  <= '0;
      r_last <= w_last;
      r_prev <= 1'b0;
      r_z    <= 4'd0;
    end else if (r_state[I_SEND]) begin
      r_pat  <= r_pat >> 1;
      r_cnt  <= r_cnt + CW'(1);
      r_prev <= r_pat[0];
      if ((r_cnt != '0) && (r_pat[0] == r_prev)) begin
        r_z <= r_z + 4'd1;
      end
    end
  end

  assign expected_z = r_z;
  assign state      = r_state;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: expected bits queued at start,
// popped and compared by a monitor whenever valid is high.
module tb_seq_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic       w;
  logic       valid;
  logic       done;
  logic [3:0] expected_z;
  logic [2:0] state;

  int checks;
  int errors;
  bit exp_q[$];

  seq_gen #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .len        (len),
    .w          (w),
    .valid      (valid),
    .done       (done),
    .expected_z (expected_z),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset && valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_extra: got valid bit %b expected no bit", w);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (w !== e) begin
          errors++;
          $display("FAIL mon_w: got %b expected %b", w, e);
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    pattern = 8'hFF; len = 4'd3; start = 1'b1;
    repeat (3) exp_q.push_back(1'b1);
    tick;
    start = 1'b0;
    tick;
    tick;
    checks++;
    if (expected_z !== 4'd1) begin
      errors++; $display("FAIL rst_pre_z: got %0d expected 1", expected_z);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'b001) begin
      errors++; $display("FAIL rst_state: got %b expected 001", state);
    end
    checks++;
    if ({w, valid, done} !== 3'b000) begin
      errors++; $display("FAIL rst_outs: got %b expected 000", {w, valid, done});
    end
    checks++;
    if (expected_z !== 4'd0) begin
      errors++; $display("FAIL rst_z: got %0d expected 0", expected_z);
    end
    exp_q.delete();
    tick;
  endtask

  task automatic test_basic;
    reset = 1'b1;
    pattern = 8'b0000_0011; len = 4'd4; start = 1'b1;
    exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'b010 || valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_send%0d: got state %b valid %b expected 010 1", i, state, valid);
      end
      tick;
    end
    checks++;
    if (state !== 3'b100 || done !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got state %b done %b valid %b expected 100 1 0", state, done, valid);
    end
    checks++;
    if (expected_z !== 4'd2) begin
      errors++; $display("FAIL basic_z: got %0d expected 2", expected_z);
    end
    tick;
    checks++;
    if (state !== 3'b001 || done !== 1'b0 || expected_z !== 4'd2) begin
      errors++;
      $display("FAIL basic_idle: got state %b done %b z %0d expected 001 0 2", state, done, expected_z);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_q: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_len_clamp;
    logic [7:0] pats [3];
    logic [3:0] lens [3];
    int         effs [3];
    int         zs   [3];
    pats = '{8'hAA, 8'h3C, 8'h01};
    lens = '{4'd0, 4'd12, 4'd1};
    effs = '{8, 8, 1};
    zs   = '{0, 5, 0};
    for (int j = 0; j < 3; j++) begin
      pattern = pats[j]; len = lens[j]; start = 1'b1;
      for (int b = 0; b < effs[j]; b++) exp_q.push_back(pats[j][b]);
      tick;
      start = 1'b0;
      for (int i = 0; i < effs[j]; i++) begin
        checks++;
        if (valid !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL clamp%0d_send%0d: got valid %b done %b expected 1 0", j, i, valid, done);
        end
        tick;
      end
      checks++;
      if (done !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL clamp%0d_done: got done %b valid %b expected 1 0", j, done, valid);
      end
      checks++;
      if (expected_z !== 4'(zs[j])) begin
        errors++;
        $display("FAIL clamp%0d_z: got %0d expected %0d", j, expected_z, zs[j]);
      end
      tick;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL clamp_q: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_start_hold;
    pattern = 8'hFF; len = 4'd8; start = 1'b1;
    repeat (8) exp_q.push_back(1'b1);
    tick;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (state !== 3'b010) begin
        errors++; $display("FAIL hold_send%0d: got state %b expected 010", i, state);
      end
      tick;
    end
    checks++;
    if (state !== 3'b100 || expected_z !== 4'd7) begin
      errors++;
      $display("FAIL hold_done: got state %b z %0d expected 100 7", state, expected_z);
    end
    pattern = 8'h05; len = 4'd3;
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    tick;
    checks++;
    if (state !== 3'b001 || expected_z !== 4'd7 || done !== 1'b0) begin
      errors++;
      $display("FAIL hold_idle: got state %b z %0d done %b expected 001 7 0", state, expected_z, done);
    end
    tick;
    start = 1'b0;
    checks++;
    if (state !== 3'b010 || expected_z !== 4'd0) begin
      errors++;
      $display("FAIL hold_restart: got state %b z %0d expected 010 0", state, expected_z);
    end
    repeat (3) tick;
    checks++;
    if (done !== 1'b1 || expected_z !== 4'd0) begin
      errors++;
      $display("FAIL hold_done2: got done %b z %0d expected 1 0", done, expected_z);
    end
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL hold_q: got %0d left expected 0", exp_q.size());
    end
  endtask

  task automatic test_abort;
    pattern = 8'h0F; len = 4'd8; start = 1'b1;
    for (int b = 0; b < 8; b++) exp_q.push_back(pattern[b]);
    tick;
    start = 1'b0;
    tick;
    tick;
    checks++;
    if (expected_z !== 4'd1) begin
      errors++; $display("FAIL abort_pre_z: got %0d expected 1", expected_z);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'b001 || expected_z !== 4'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst: got state %b z %0d valid %b expected 001 0 0", state, expected_z, valid);
    end
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      tick;
      if (i == 2) reset = 1'b1;
      checks++;
      if (done !== 1'b0 || state !== 3'b001) begin
        errors++;
        $display("FAIL abort_after%0d: got done %b state %b expected 0 001", i, done, state);
      end
    end
  endtask

  task automatic test_capture;
    pattern = 8'hB4; len = 4'd5; start = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    tick;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid !== 1'b1) begin
        errors++; $display("FAIL cap_send%0d: got valid %b expected 1", i, valid);
      end
      pattern = 8'($urandom);
      len = 4'($urandom_range(1, 15));
      tick;
    end
    checks++;
    if (done !== 1'b1 || expected_z !== 4'd1) begin
      errors++;
      $display("FAIL cap_done: got done %b z %0d expected 1 1", done, expected_z);
    end
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cap_q: got %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    start = 1'b0;
    pattern = 8'h00;
    len = 4'd0;
    #12;
    test_reset;
    test_basic;
    test_len_clamp;
    test_start_hold;
    test_abort;
    test_capture;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter: WIDTH, default 8, maximum pattern length in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: start  input  1  request to transmit; sampled only in IDLE.
REQ-005 Port: pattern  input  WIDTH  bits to transmit, LSB first; captured on start acceptance.
REQ-006 Port: len  input  4  number of bits to send; captured on start acceptance.
REQ-007 Port: w  output  1  serial stimulus bit for the sequence detector.
REQ-008 Port: valid  output  1  high while w carries a pattern bit.
REQ-009 Port: done  output  1  one-cycle pulse after the last bit.
REQ-010 Port: expected_z  output  4  count of detector hits the sent stream produces.
REQ-011 Port: state  output  3  one-hot state, bits {DONE, SEND, IDLE}.

Function
REQ-012 The FSM SHALL be one-hot with exactly three states: IDLE (001), SEND (010) and DONE (100).
REQ-013 In IDLE, start=1 at a rising edge SHALL capture pattern and len, clear expected_z and the bit counter, and enter SEND.
REQ-014 Effective length SHALL be len when 1 <= len <= WIDTH; len = 0 or len > WIDTH SHALL be treated as WIDTH.
REQ-015 In SEND, w SHALL equal captured bit k during the k-th SEND cycle (k = 0 first) and valid SHALL be 1.
REQ-016 SEND SHALL last exactly the effective-length number of cycles, then go to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1 and valid=0, then go to IDLE.
REQ-018 Outside SEND, w SHALL be 0 and valid SHALL be 0.
REQ-019 done SHALL be 1 only in DONE.
REQ-020 start SHALL be ignored in SEND and DONE; a request therefore needs at least one IDLE cycle.
REQ-021 Latency: the first bit SHALL appear on w in the cycle immediately after the edge that accepts start.
REQ-022 expected_z counting rule:
- increments at the edge that ends SEND cycle k (k >= 1) when bit k equals bit k-1;
- bit 0 never counts.
REQ-023 Range: the maximum count is WIDTH-1; expected_z SHALL not wrap for WIDTH <= 16.
REQ-024 expected_z SHALL be final in the DONE cycle and SHALL hold until the next accepted start.
REQ-025 Changes on pattern or len after start acceptance SHALL NOT affect the transmission in progress.
REQ-026 state SHALL always equal the registered one-hot state vector.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for clk, force these values:
- state=001;
- w=0, valid=0, done=0;
- expected_z=0;
- bit counter and captured pattern cleared.
REQ-028 Reset asserted during SEND or DONE SHALL abort the transmission; no done pulse SHALL follow.
REQ-029 After reset deasserts, the block SHALL accept start at the first rising edge.

Verification
REQ-030 Reset: drive reset=0 mid-cycle with no clock edge -> state=001, w=0, valid=0, done=0, expected_z=0 at once.
REQ-031 Basic send: pattern=8'b0000_0011, len=4, one-cycle start ->
- w = 1,1,0,0 over 4 cycles with valid=1;
- done=1 in cycle 5;
- expected_z=2.
REQ-032 Length clamp, alternating bits: pattern=8'hAA, len=0 ->
- 8 bits w = 0,1,0,1,0,1,0,1;
- expected_z=0;
- done in cycle 9.
REQ-033 All ones and start timing: pattern=8'hFF, len=8 -> expected_z=7; start held through SEND and DONE ->
- ignored until IDLE;
- accepted at the first IDLE edge, restarting with expected_z cleared.
REQ-034 Abort: reset pulsed low after 2 SEND bits of 8'h0F, len=8 -> state=001, expected_z=0, no done pulse.
REQ-035 Capture isolation: change pattern and len during SEND -> w sequence identical to the values captured at start.
